// File: rtl/div_pkg.sv
// Shared types and sizing for the signed restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      FIX,
      DONE
   } divState_t;

   localparam int DEF_WIDTH = 32;
   localparam int CNT_W     = $clog2(DEF_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] remIn,
   input  logic             inBit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] remOut,
   output logic             qBit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // remIn < divisor <= 2^(WIDTH-1), so bit WIDTH of diff is its sign
   always_comb begin
      shifted = {remIn, inBit};
      diff    = shifted - {1'b0, divisor};
      qBit    = ~diff[WIDTH];
      remOut  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_integrated.sv
// Signed 2W/W restoring divider with divide-by-zero and overflow flags.
module div_integrated
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   Dividend,
   input  logic [WIDTH-1:0]     Divisor,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     Quotient,
   output logic [WIDTH-1:0]     Remainder,
   output logic                 divByZero,
   output logic                 overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] NEG_LIM = {1'b1, {(WIDTH-1){1'b0}}};

   divState_t state;
   divState_t nextState;

   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   divReg;
   logic [WIDTH-1:0]   remReg;
   logic [WIDTH-1:0]   quoReg;
   logic [WIDTH-1:0]   stepRem;
   logic               stepBit;
   logic               signQ;
   logic               signR;
   logic               preDbz;
   logic               preOvf;
   logic               fault;
   logic               fixOvf;
   logic [2*WIDTH-1:0] dendMag;
   logic [WIDTH-1:0]   dsorMag;

   assign dendMag = Dividend[2*WIDTH-1] ? -Dividend : Dividend;
   assign dsorMag = Divisor[WIDTH-1] ? -Divisor : Divisor;
   assign fault   = preDbz | preOvf;
   // negative results may reach -2^(WIDTH-1), positive ones may not
   assign fixOvf  = signQ ? (quoReg > NEG_LIM) : quoReg[WIDTH-1];
   assign busy    = (state == ITER) || (state == FIX);
   assign done    = (state == DONE);

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .remIn  (remReg),
      .inBit  (quoReg[WIDTH-1]),
      .divisor(divReg),
      .remOut (stepRem),
      .qBit   (stepBit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (start) nextState = ITER;
         ITER: begin
            if (fault)            nextState = DONE;
            else if (cnt == LAST) nextState = FIX;
         end
         FIX:  nextState = DONE;
         DONE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         divReg    <= '0;
         remReg    <= '0;
         quoReg    <= '0;
         signQ     <= 1'b0;
         signR     <= 1'b0;
         preDbz    <= 1'b0;
         preOvf    <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         divByZero <= 1'b0;
         overflow  <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            cnt    <= '0;
            divReg <= dsorMag;
            remReg <= dendMag[2*WIDTH-1:WIDTH];
            quoReg <= dendMag[WIDTH-1:0];
            signQ  <= Dividend[2*WIDTH-1] ^ Divisor[WIDTH-1];
            signR  <= Dividend[2*WIDTH-1];
            preDbz <= (Divisor == '0);
            preOvf <= (Divisor != '0) &&
                      (dendMag[2*WIDTH-1:WIDTH] >= dsorMag);
         end
      end else if (state == ITER) begin
         if (fault) begin
            Quotient  <= '0;
            Remainder <= '0;
            divByZero <= preDbz;
            overflow  <= preOvf;
         end else begin
            remReg <= stepRem;
            quoReg <= {quoReg[WIDTH-2:0], stepBit};
            cnt    <= cnt + CW'(1);
         end
      end else if (state == FIX) begin
         divByZero <= 1'b0;
         overflow  <= fixOvf;
         Quotient  <= fixOvf ? '0 : (signQ ? -quoReg : quoReg);
         Remainder <= fixOvf ? '0 : (signR ? -remReg : remReg);
      end
   end

endmodule

// File: tb/tb_div_integrated.sv
// Directed bench for div_integrated with WIDTH=32.
module tb_div_integrated;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [2*W-1:0] Dividend;
   logic [W-1:0]   Divisor;
   logic           busy;
   logic           done;
   logic [W-1:0]   Quotient;
   logic [W-1:0]   Remainder;
   logic           divByZero;
   logic           overflow;

   int nAssert = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   div_integrated #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .Dividend (Dividend),
      .Divisor  (Divisor),
      .busy     (busy),
      .done     (done),
      .Quotient (Quotient),
      .Remainder(Remainder),
      .divByZero(divByZero),
      .overflow (overflow)
   );

   // Edge 1 is the accepting edge; returns at the negedge where done is seen.
   task automatic runOp(input logic [2*W-1:0] dend, input logic [W-1:0] dsor,
                        input int rp, input logic [2*W-1:0] rpDend,
                        input logic [W-1:0] rpDsor,
                        output int edges, output bit busyOk);
      busyOk = 1'b1;
      edges  = 0;
      @(negedge clk);
      Dividend = dend;
      Divisor  = dsor;
      start    = 1'b1;
      @(posedge clk);
      edges = 1;
      #1;
      start    = 1'b0;
      Dividend = ~dend;
      Divisor  = dsor + 32'd5;
      while (edges < 60) begin
         @(negedge clk);
         if (done === 1'b1) break;
         if (busy !== 1'b1) busyOk = 1'b0;
         @(posedge clk);
         edges++;
         #1;
         if (edges == rp) begin
            start    = 1'b1;
            Dividend = rpDend;
            Divisor  = rpDsor;
         end else begin
            start = 1'b0;
         end
      end
      if (done === 1'b1 && busy !== 1'b0) busyOk = 1'b0;
   endtask

   task automatic test_reset;
      reset    = 1'b0;
      start    = 1'b0;
      Dividend = '0;
      Divisor  = '0;
      #2 reset = 1'b1;
      #1;
      nAssert++;
      if ({busy, done, divByZero, overflow, Quotient, Remainder} !== '0) begin
         nFail++;
         $display("FAIL reset_async: got b%b d%b z%b o%b q%h r%h want all 0",
                  busy, done, divByZero, overflow, Quotient, Remainder);
      end
      repeat (2) @(negedge clk);
      nAssert++;
      if ({busy, done} !== 2'b00) begin
         nFail++;
         $display("FAIL reset_held: got busy=%b done=%b want 0 0", busy, done);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic;
      int e;
      bit bOk;
      runOp(64'd100, 32'd7, 0, '0, '0, e, bOk);
      nAssert++;
      if (e !== 34) begin
         nFail++;
         $display("FAIL basic_latency: got %0d edges want 34", e);
      end
      nAssert++;
      if (Quotient !== 32'd14 || Remainder !== 32'd2) begin
         nFail++;
         $display("FAIL basic_result: got q=%0d r=%0d want 14 2",
                  $signed(Quotient), $signed(Remainder));
      end
      nAssert++;
      if ({divByZero, overflow} !== 2'b00) begin
         nFail++;
         $display("FAIL basic_flags: got z=%b o=%b want 0 0", divByZero, overflow);
      end
      nAssert++;
      if (bOk !== 1'b1) begin
         nFail++;
         $display("FAIL basic_busy: busy profile wrong, got %b want 1", bOk);
      end
      @(negedge clk);
      nAssert++;
      if (done !== 1'b0) begin
         nFail++;
         $display("FAIL done_pulse: got done=%b in next cycle want 0", done);
      end
   endtask

   task automatic test_signs;
      logic [2*W-1:0] dend [3];
      logic [W-1:0]   dsor [3];
      int             expQ [3];
      int             expR [3];
      int             e;
      bit             bOk;
      dend = '{-64'sd100, 64'd100, -64'sd100};
      dsor = '{32'd7, -32'sd7, -32'sd7};
      expQ = '{-14, -14, 14};
      expR = '{-2, 2, -2};
      for (int i = 0; i < 3; i++) begin
         runOp(dend[i], dsor[i], 0, '0, '0, e, bOk);
         nAssert++;
         if ($signed(Quotient) !== expQ[i] || $signed(Remainder) !== expR[i]
             || e !== 34) begin
            nFail++;
            $display("FAIL signs_%0d: got q=%0d r=%0d e=%0d want %0d %0d 34", i,
                     $signed(Quotient), $signed(Remainder), e, expQ[i], expR[i]);
         end
      end
   endtask

   task automatic test_div_zero;
      int e;
      bit bOk;
      runOp(64'd12345, 32'd0, 0, '0, '0, e, bOk);
      nAssert++;
      if (e !== 2) begin
         nFail++;
         $display("FAIL dbz_latency: got %0d edges want 2", e);
      end
      nAssert++;
      if ({divByZero, overflow} !== 2'b10 || Quotient !== '0 || Remainder !== '0) begin
         nFail++;
         $display("FAIL dbz_result: got z=%b o=%b q=%h r=%h want 1 0 0 0",
                  divByZero, overflow, Quotient, Remainder);
      end
   endtask

   task automatic test_precheck_ovf;
      int e;
      bit bOk;
      runOp(64'h0000_0001_0000_0000, 32'd1, 0, '0, '0, e, bOk);
      nAssert++;
      if (e !== 2) begin
         nFail++;
         $display("FAIL preovf_latency: got %0d edges want 2", e);
      end
      nAssert++;
      if ({divByZero, overflow} !== 2'b01 || Quotient !== '0 || Remainder !== '0) begin
         nFail++;
         $display("FAIL preovf_result: got z=%b o=%b q=%h r=%h want 0 1 0 0",
                  divByZero, overflow, Quotient, Remainder);
      end
   endtask

   task automatic test_boundary;
      int e;
      bit bOk;
      runOp(64'hFFFF_FFFF_0000_0000, 32'd2, 0, '0, '0, e, bOk);
      nAssert++;
      if (Quotient !== 32'h8000_0000 || Remainder !== '0 || overflow !== 1'b0
          || e !== 34) begin
         nFail++;
         $display("FAIL min_quot: got q=%h r=%h o=%b e=%0d want 80000000 0 0 34",
                  Quotient, Remainder, overflow, e);
      end
      runOp(64'h0000_0000_8000_0000, 32'd1, 0, '0, '0, e, bOk);
      nAssert++;
      if (overflow !== 1'b1 || divByZero !== 1'b0 || Quotient !== '0
          || Remainder !== '0 || e !== 34) begin
         nFail++;
         $display("FAIL fix_ovf: got o=%b z=%b q=%h r=%h e=%0d want 1 0 0 0 34",
                  overflow, divByZero, Quotient, Remainder, e);
      end
   endtask

   task automatic test_ignore_start;
      int e;
      bit bOk;
      runOp(64'd100, 32'd7, 10, 64'd50, 32'd3, e, bOk);
      nAssert++;
      if (Quotient !== 32'd14 || Remainder !== 32'd2 || e !== 34 || bOk !== 1'b1) begin
         nFail++;
         $display("FAIL ignore_start: got q=%0d r=%0d e=%0d busy=%b want 14 2 34 1",
                  Quotient, Remainder, e, bOk);
      end
      repeat (3) @(negedge clk);
      nAssert++;
      if ({busy, done} !== 2'b00) begin
         nFail++;
         $display("FAIL no_queue: got busy=%b done=%b want 0 0", busy, done);
      end
   endtask

   task automatic test_hold;
      logic [W-1:0] q0;
      logic [W-1:0] r0;
      int           e;
      bit           bOk;
      runOp(64'd1000, 32'd3, 0, '0, '0, e, bOk);
      q0 = Quotient;
      r0 = Remainder;
      nAssert++;
      if (q0 !== 32'd333 || r0 !== 32'd1) begin
         nFail++;
         $display("FAIL hold_setup: got q=%0d r=%0d want 333 1", q0, r0);
      end
      Dividend = 64'd77;
      Divisor  = 32'd0;
      repeat (5) @(negedge clk);
      nAssert++;
      if (Quotient !== 32'd333 || Remainder !== 32'd1 || divByZero !== 1'b0) begin
         nFail++;
         $display("FAIL hold: got q=%0d r=%0d z=%b want 333 1 0",
                  Quotient, Remainder, divByZero);
      end
   endtask

   task automatic test_back_to_back;
      int e;
      bit bOk;
      runOp(64'd100, 32'd7, 0, '0, '0, e, bOk);
      Dividend = 64'd1000;
      Divisor  = -32'sd9;
      start    = 1'b1;
      @(posedge clk);
      #1;
      nAssert++;
      if (busy !== 1'b0) begin
         nFail++;
         $display("FAIL start_in_done: got busy=%b want 0", busy);
      end
      runOp(64'd1000, -32'sd9, 0, '0, '0, e, bOk);
      nAssert++;
      if ($signed(Quotient) !== -111 || Remainder !== 32'd1 || e !== 34) begin
         nFail++;
         $display("FAIL back_to_back: got q=%0d r=%0d e=%0d want -111 1 34",
                  $signed(Quotient), $signed(Remainder), e);
      end
   endtask

   task automatic test_reset_mid;
      bit sawDone;
      int e;
      bit bOk;
      @(negedge clk);
      Dividend = 64'd500;
      Divisor  = 32'd9;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (19) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      nAssert++;
      if ({busy, done, divByZero, overflow, Quotient, Remainder} !== '0) begin
         nFail++;
         $display("FAIL reset_mid: got b%b d%b z%b o%b q%h r%h want all 0",
                  busy, done, divByZero, overflow, Quotient, Remainder);
      end
      @(negedge clk);
      reset   = 1'b0;
      sawDone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) sawDone = 1'b1;
      end
      nAssert++;
      if (sawDone !== 1'b0) begin
         nFail++;
         $display("FAIL reset_abort: got done pulse=%b want 0", sawDone);
      end
      runOp(64'd100, 32'd7, 0, '0, '0, e, bOk);
      nAssert++;
      if (Quotient !== 32'd14 || Remainder !== 32'd2 || e !== 34) begin
         nFail++;
         $display("FAIL after_reset: got q=%0d r=%0d e=%0d want 14 2 34",
                  Quotient, Remainder, e);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_div_zero();
      test_precheck_ovf();
      test_boundary();
      test_ignore_start();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               nAssert, nFail);
      $finish;
   end

endmodule

// File: doc/div_integrated.md
DIV_INTEGRATED -- requirements
Module: div_integrated

Interface
REQ-001 Parameter WIDTH, default 32, sets divisor/quotient/remainder width; dividend is 2*WIDTH.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 Dividend  input  2*WIDTH  signed two's-complement dividend; captured when start is accepted.
REQ-007 Divisor  input  WIDTH  signed two's-complement divisor; captured when start is accepted.
REQ-008 busy  output  1  high from the edge after acceptance until the edge that asserts done.
REQ-009 done  output  1  one-cycle pulse; results valid from this cycle on.
REQ-010 Quotient  output  WIDTH  signed quotient, registered.
REQ-011 Remainder  output  WIDTH  signed remainder, registered.
REQ-012 divByZero  output  1  registered; set with done when Divisor==0.
REQ-013 overflow  output  1  registered; set with done when the quotient is not representable in signed WIDTH bits.

Function
REQ-014 FSM states: IDLE, ITER, FIX, DONE; reset state IDLE.
REQ-015 IDLE with start=1 at an edge: capture magnitudes of operands, record signs, clear the iteration counter, and go to ITER; with start=0, remain in IDLE.
REQ-016 Pre-check at capture: if Divisor==0, go directly to DONE with divByZero=1; else if |Dividend|[2*WIDTH-1:WIDTH] >= |Divisor|, go directly to DONE with overflow=1.
REQ-017 ITER: one restoring shift-subtract step per cycle, WIDTH cycles exactly; after step WIDTH-1, go to FIX.
REQ-018 FIX: quotient sign = sign(Dividend) XOR sign(Divisor); remainder takes the sign of Dividend (truncating division).
REQ-019 FIX: if the magnitude quotient exceeds 2^(WIDTH-1)-1 for a positive result, or 2^(WIDTH-1) for a negative result, set overflow=1.
REQ-020 FIX: load Quotient/Remainder on no-fault; go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-022 Latency: normal operation asserts done in the cycle following the (WIDTH+2)th edge after acceptance (34 edges for WIDTH=32); a pre-check fault asserts done after 2 edges.
REQ-023 Fault results: Quotient=0, Remainder=0; at most one of divByZero/overflow is set.
REQ-024 Quotient, Remainder and the flags hold their values until the next done; all of them update only in the cycle that asserts done.
REQ-025 A start asserted while busy, or in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-026 Dividend/Divisor changes after acceptance SHALL NOT affect the result.
REQ-027 A back-to-back start in the IDLE cycle directly after done SHALL be accepted.

Reset
REQ-028 Asserting reset SHALL, immediately and asynchronously, force state=IDLE, busy=0, done=0, Quotient=0, Remainder=0, divByZero=0, overflow=0, and clear the internal counter and working registers.
REQ-029 Reset mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.

Structure
REQ-030 Shared package div_pkg SHALL hold the FSM state type, the default WIDTH, and the counter width $clog2(WIDTH).
REQ-031 One combinational sub-module, div_step, SHALL implement a single restoring iteration (partial remainder, divisor -> next remainder, quotient bit).
REQ-032 Target size: 120-400 lines of RTL, excluding the package.

Verification
REQ-033 Dividend=100, Divisor=7, start pulse -> done 34 edges later; Quotient=14, Remainder=2, both flags=0; busy high throughout.
REQ-034 Dividend=-100, Divisor=7 -> Quotient=-14, Remainder=-2; Dividend=100, Divisor=-7 -> Quotient=-14, Remainder=2.
REQ-035 Divisor=0, any Dividend -> done after 2 edges, divByZero=1, Quotient=0, Remainder=0; Dividend=0x0000_0001_0000_0000, Divisor=1 -> overflow=1 after 2 edges.
REQ-036 Boundary: Dividend=0xFFFF_FFFF_0000_0000 (-2^32), Divisor=2 -> Quotient=0x8000_0000, no overflow; Dividend=0x0000_0000_8000_0000, Divisor=1 -> overflow=1 set in FIX, done at 34 edges.
REQ-037 Start re-pulsed at edge 10 with different operands -> ignored, result matches the first operands; reset at edge 20 -> no done, all outputs 0, and the next start completes correctly.
